transmit_dac: RTL

//  Serial transmitter for the equaliser output path: takes one 12-bit sample and sends it as a
//  16-bit frame (SYNC/SCLK/DIN, DAC121S101-style) to the external DAC, MSB first.

---
 rtl/dac_pkg.sv | 27 ++
 rtl/piso_shift16.sv | 27 ++
 rtl/transmit_dac.sv | 107 ++++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC serial transmit path: frame geometry, power-down codes, FSM states.
package dac_pkg;

    localparam int FRAME_W = 16;
    localparam int CTRL_W  = 4;
    localparam int DATA_W  = FRAME_W - CTRL_W;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } dac_state_e;

    // Frame layout seen by the DAC: two don't-care zeros, power-down code, then data MSB first.
    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic [1:0]        pd,
        input logic [DATA_W-1:0] data
    );
        return {2'b00, pd, data};
    endfunction

endpackage

// File: rtl/piso_shift16.sv
// 16-bit parallel-in/serial-out register; shifts left filling zeros so the line idles low.
module piso_shift16
    import dac_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [FRAME_W-1:0] pdata,
    output logic               sout
);

    logic [FRAME_W-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= pdata;
        end else if (shift) begin
            sreg <= {sreg[FRAME_W-2:0], 1'b0};
        end
    end

    assign sout = sreg[FRAME_W-1];

endmodule

// File: rtl/transmit_dac.sv
// Serial transmitter to a DAC121S101-style converter: one 16-bit SYNC/DIN frame per accepted sample.
module transmit_dac
    import dac_pkg::*;
#(
    parameter int         DATA_W     = 12,
    parameter logic [1:0] PD_MODE    = PD_NORMAL,
    parameter bit         SIGNED_IN  = 1'b1,
    parameter int         GAP_CYCLES = 2
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              sync,
    output logic              sdata,
    output logic              tx_done_tick,
    output dac_state_e        fsm_state
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    dac_state_e  state, state_next;
    logic [3:0]  bit_cnt, bit_cnt_next;
    logic [3:0]  gap_cnt, gap_cnt_next;
    logic        sync_next;
    logic        done_next;
    logic        load;
    logic        shift;
    logic [DATA_W-1:0] data_conv;

    // Two's complement to offset binary is just an MSB flip.
    assign data_conv = SIGNED_IN ? {~din[DATA_W-1], din[DATA_W-2:0]} : din;

    always_ff @(posedge sclk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            gap_cnt      <= '0;
            sync         <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            gap_cnt      <= gap_cnt_next;
            sync         <= sync_next;
            tx_done_tick <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        gap_cnt_next = gap_cnt;
        sync_next    = 1'b1;
        done_next    = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    load         = 1'b1;
                    bit_cnt_next = '0;
                    sync_next    = 1'b0;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (bit_cnt == 4'd15) begin
                    // Last bit has been on the line for a full cycle; close the frame.
                    bit_cnt_next = '0;
                    gap_cnt_next = '0;
                    done_next    = 1'b1;
                    state_next   = ST_GAP;
                end else begin
                    bit_cnt_next = bit_cnt + 4'd1;
                    sync_next    = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_next = '0;
                    state_next   = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    piso_shift16 u_piso (
        .clk   (sclk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .pdata (pack_frame(PD_MODE, data_conv)),
        .sout  (sdata)
    );

    assign ready     = (state == ST_IDLE);
    assign fsm_state = state;

endmodule
